// File: rtl/conv1_relu_if.sv
// Start/finish handshake plus weight and activation SRAM ports of the conv1 stage.
interface conv1_relu_if;
  logic        start;
  logic        finish;

  logic        weight_cen;
  logic [3:0]  weight_wea0;
  logic [3:0]  weight_wea1;
  logic [15:0] weight_addr0;
  logic [15:0] weight_addr1;
  logic [31:0] weight_rdata0;
  logic [31:0] weight_rdata1;

  logic        act_cen;
  logic [3:0]  act_wea0;
  logic [3:0]  act_wea1;
  logic [15:0] act_addr0;
  logic [15:0] act_addr1;
  logic [31:0] act_wdata0;
  logic [31:0] act_wdata1;
  logic [31:0] act_rdata0;
  logic [31:0] act_rdata1;

  // Layer engine side: drives the SRAMs, receives read data and start.
  modport master (
    input  start, weight_rdata0, weight_rdata1, act_rdata0, act_rdata1,
    output finish, weight_cen, weight_wea0, weight_wea1, weight_addr0, weight_addr1,
           act_cen, act_wea0, act_wea1, act_addr0, act_addr1, act_wdata0, act_wdata1
  );

  // SRAM / controller side.
  modport slave (
    output start, weight_rdata0, weight_rdata1, act_rdata0, act_rdata1,
    input  finish, weight_cen, weight_wea0, weight_wea1, weight_addr0, weight_addr1,
           act_cen, act_wea0, act_wea1, act_addr0, act_addr1, act_wdata0, act_wdata1
  );
endinterface

// File: rtl/conv1_relu.sv
// First LeNet conv stage: 5x5 valid conv over a 32x32 int8 image, 6 channels of 28x28,
// bias + ReLU + shift + saturate, one output row (7 packed words) at a time.
module conv1_relu #(
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 1024,
  parameter int unsigned W_BASE   = 0,
  parameter int unsigned N_CH     = 6,
  parameter int unsigned SHIFT    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  conv1_relu_if.master bus_io
);

  typedef enum logic [2:0] {StIdle, StLdW, StLdRow, StComp, StWr, StFin} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cyc_q, cyc_d;
  logic [3:0]            ch_q, ch_d;
  logic [4:0]            row_q, row_d;

  logic [199:0]          kern_q;       // 25 taps, byte k = tap (k/5, k%5)
  logic [31:0]           bias_q;
  logic [31:0]           win_q [40];   // 5 image rows x 8 words
  logic signed [20:0]    sum_q, sum_d;
  logic [7:0]            obuf_q [28];

  logic [255:0]          row_bits [5];
  logic [31:0]           out_word [8];

  // Bias, ReLU, truncating shift and saturation to int8.
  function automatic logic [7:0] requant(input logic signed [20:0] s, input logic [31:0] b);
    logic [31:0] res;
    logic [31:0] sh;
    res = {{11{s[20]}}, s} + b;
    sh  = res >> SHIFT;
    if (res[31]) return 8'd0;
    if (sh > 32'd127) return 8'd127;
    return sh[7:0];
  endfunction

  // State and loop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      ch_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
    end
  end

  // Next state: LD_W 5, LD_ROW 21, COMP 29, WR 4 cycles; channel outer, row inner.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 5'd1;
    ch_d    = ch_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        cyc_d = '0;
        if (bus_io.start) begin
          state_d = StLdW;
          ch_d    = '0;
          row_d   = '0;
        end
      end
      StLdW: if (cyc_q == 5'd4) begin
        state_d = StLdRow;
        cyc_d   = '0;
      end
      StLdRow: if (cyc_q == 5'd20) begin
        state_d = StComp;
        cyc_d   = '0;
      end
      StComp: if (cyc_q == 5'd28) begin
        state_d = StWr;
        cyc_d   = '0;
      end
      StWr: if (cyc_q == 5'd3) begin
        cyc_d = '0;
        if (row_q != 5'd27) begin
          row_d   = row_q + 5'd1;
          state_d = StLdRow;
        end else if (ch_q != 4'(N_CH - 1)) begin
          ch_d    = ch_q + 4'd1;
          row_d   = '0;
          state_d = StLdW;
        end else begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        cyc_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Unpack the window rows and output bytes into flat views.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      row_bits[i] = '0;
      for (int w = 0; w < 8; w++) row_bits[i][32*w +: 32] = win_q[8*i+w];
    end
    for (int w = 0; w < 7; w++) begin
      out_word[w] = {obuf_q[4*w+3], obuf_q[4*w+2], obuf_q[4*w+1], obuf_q[4*w]};
    end
    out_word[7] = '0;
  end

  // 25-tap signed MAC for column cyc_q; column index wraps so the unused cycle 28 stays in range.
  always_comb begin
    logic signed [7:0]  pix;
    logic signed [7:0]  tap;
    logic signed [15:0] prod;
    logic [4:0]         col;
    pix   = '0;
    tap   = '0;
    prod  = '0;
    col   = '0;
    sum_d = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        col   = 5'(cyc_q + 5'(j));
        pix   = row_bits[i][{col, 3'b000} +: 8];
        tap   = kern_q[8*(5*i+j) +: 8];
        prod  = pix * tap;
        sum_d = sum_d + {{5{prod[15]}}, prod};
      end
    end
  end

  // Capture weights, window words, MAC pipeline and requantised output bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kern_q <= '0;
      bias_q <= '0;
      sum_q  <= '0;
      for (int n = 0; n < 40; n++) win_q[n] <= '0;
      for (int n = 0; n < 28; n++) obuf_q[n] <= '0;
    end else begin
      if (state_q == StLdW) begin
        case (cyc_q)
          5'd1: kern_q[63:0]    <= {bus_io.weight_rdata1, bus_io.weight_rdata0};
          5'd2: kern_q[127:64]  <= {bus_io.weight_rdata1, bus_io.weight_rdata0};
          5'd3: kern_q[191:128] <= {bus_io.weight_rdata1, bus_io.weight_rdata0};
          5'd4: begin
            kern_q[199:192] <= bus_io.weight_rdata0[7:0];
            bias_q          <= bus_io.weight_rdata1;
          end
          default: ;
        endcase
      end
      if (state_q == StLdRow && cyc_q != 5'd0) begin
        win_q[{cyc_q - 5'd1, 1'b0}] <= bus_io.act_rdata0;
        win_q[{cyc_q - 5'd1, 1'b1}] <= bus_io.act_rdata1;
      end
      if (state_q == StComp) begin
        if (cyc_q < 5'd28) sum_q <= sum_d;
        if (cyc_q != 5'd0) obuf_q[cyc_q - 5'd1] <= requant(sum_q, bias_q);
      end
    end
  end

  // SRAM strobes and finish pulse; everything idles at zero with enables high.
  always_comb begin
    logic [15:0] obase;
    obase = 16'(OUT_BASE) + 16'(ch_q) * 16'd196 + 16'(row_q) * 16'd7;
    bus_io.finish       = 1'b0;
    bus_io.weight_cen   = 1'b1;
    bus_io.weight_wea0  = '0;
    bus_io.weight_wea1  = '0;
    bus_io.weight_addr0 = '0;
    bus_io.weight_addr1 = '0;
    bus_io.act_cen      = 1'b1;
    bus_io.act_wea0     = '0;
    bus_io.act_wea1     = '0;
    bus_io.act_addr0    = '0;
    bus_io.act_addr1    = '0;
    bus_io.act_wdata0   = '0;
    bus_io.act_wdata1   = '0;
    unique case (state_q)
      StLdW: if (cyc_q < 5'd4) begin
        bus_io.weight_cen   = 1'b0;
        bus_io.weight_addr0 = 16'(W_BASE) + 16'(ch_q) * 16'd8 + 16'({cyc_q, 1'b0});
        bus_io.weight_addr1 = bus_io.weight_addr0 + 16'd1;
      end
      StLdRow: if (cyc_q < 5'd20) begin
        // Window word n lives at IN_BASE + (r + n/8)*8 + n%8 = IN_BASE + r*8 + n.
        bus_io.act_cen   = 1'b0;
        bus_io.act_addr0 = 16'(IN_BASE) + 16'(row_q) * 16'd8 + 16'({cyc_q, 1'b0});
        bus_io.act_addr1 = bus_io.act_addr0 + 16'd1;
      end
      StWr: begin
        bus_io.act_cen    = 1'b0;
        bus_io.act_wea0   = 4'b1111;
        bus_io.act_addr0  = obase + 16'({cyc_q[1:0], 1'b0});
        bus_io.act_wdata0 = out_word[{cyc_q[1:0], 1'b0}];
        if (cyc_q != 5'd3) begin
          bus_io.act_wea1   = 4'b1111;
          bus_io.act_addr1  = bus_io.act_addr0 + 16'd1;
          bus_io.act_wdata1 = out_word[{cyc_q[1:0], 1'b1}];
        end
      end
      StFin: bus_io.finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv1_relu.sv
// Directed bench for conv1_relu: two instances (SHIFT=0 and SHIFT=8) share behavioural SRAMs.
module tb_conv1_relu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, clr;
  int   tests, fails;

  conv1_relu_if ifa ();
  conv1_relu_if ifb ();

  conv1_relu #(.SHIFT(0)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus_io(ifa));
  conv1_relu #(.SHIFT(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus_io(ifb));

  logic [31:0] img_mem [256];
  logic [31:0] wt_mem  [64];
  logic [31:0] out_mem [4096];

  logic [31:0] wt_rd0, wt_rd1, act_rd0, act_rd1;
  int          wr_words, wr_cyc, wea_err, bad_wr, bad_rd, wwea_err, acc_cnt;
  logic [15:0] min_addr, max_addr;

  assign ifa.start = start_a;
  assign ifb.start = start_b;
  assign ifa.weight_rdata0 = wt_rd0;
  assign ifa.weight_rdata1 = wt_rd1;
  assign ifb.weight_rdata0 = wt_rd0;
  assign ifb.weight_rdata1 = wt_rd1;
  assign ifa.act_rdata0 = act_rd0;
  assign ifa.act_rdata1 = act_rd1;
  assign ifb.act_rdata0 = act_rd0;
  assign ifb.act_rdata1 = act_rd1;

  // Only one instance runs at a time; pick whichever has its enable low.
  logic        m_wcen, m_acen;
  logic [15:0] m_waddr0, m_waddr1, m_aaddr0, m_aaddr1;
  logic [3:0]  m_wwea, m_awea0, m_awea1;
  logic [31:0] m_awdata0, m_awdata1;
  assign m_wcen    = ifa.weight_cen & ifb.weight_cen;
  assign m_waddr0  = !ifa.weight_cen ? ifa.weight_addr0 : ifb.weight_addr0;
  assign m_waddr1  = !ifa.weight_cen ? ifa.weight_addr1 : ifb.weight_addr1;
  assign m_wwea    = ifa.weight_wea0 | ifa.weight_wea1 | ifb.weight_wea0 | ifb.weight_wea1;
  assign m_acen    = ifa.act_cen & ifb.act_cen;
  assign m_aaddr0  = !ifa.act_cen ? ifa.act_addr0 : ifb.act_addr0;
  assign m_aaddr1  = !ifa.act_cen ? ifa.act_addr1 : ifb.act_addr1;
  assign m_awea0   = !ifa.act_cen ? ifa.act_wea0 : ifb.act_wea0;
  assign m_awea1   = !ifa.act_cen ? ifa.act_wea1 : ifb.act_wea1;
  assign m_awdata0 = !ifa.act_cen ? ifa.act_wdata0 : ifb.act_wdata0;
  assign m_awdata1 = !ifa.act_cen ? ifa.act_wdata1 : ifb.act_wdata1;

  // SRAM model with one-cycle read latency plus write bookkeeping.
  always @(posedge clk) begin
    if (!m_wcen) begin
      wt_rd0 <= wt_mem[m_waddr0[5:0]];
      wt_rd1 <= wt_mem[m_waddr1[5:0]];
    end
    if (!m_acen && m_awea0 == 4'h0) begin
      act_rd0 <= img_mem[m_aaddr0[7:0]];
      act_rd1 <= img_mem[m_aaddr1[7:0]];
      if (m_aaddr0 > 16'd255 || m_aaddr1 > 16'd255) bad_rd <= bad_rd + 1;
    end
    if (m_wwea != 4'h0) wwea_err <= wwea_err + 1;
    if (!m_wcen || !m_acen) acc_cnt <= acc_cnt + 1;
    if (clr) begin
      for (int a = 0; a < 4096; a++) out_mem[a] <= 32'hDEAD_BEEF;
      wr_words <= 0;
      wr_cyc   <= 0;
      wea_err  <= 0;
      bad_wr   <= 0;
      bad_rd   <= 0;
      min_addr <= 16'hFFFF;
      max_addr <= 16'h0000;
    end else if (!m_acen && m_awea0 != 4'h0) begin
      wr_cyc  <= wr_cyc + 1;
      wea_err <= wea_err
                 + (((m_awea1 == 4'h0) != (wr_cyc % 4 == 3)) ? 1 : 0)
                 + ((m_awea0 != 4'hF) ? 1 : 0)
                 + ((m_awea1 != 4'h0 && m_awea1 != 4'hF) ? 1 : 0);
      out_mem[m_aaddr0[11:0]] <= m_awdata0;
      if (m_awea1 != 4'h0) out_mem[m_aaddr1[11:0]] <= m_awdata1;
      wr_words <= wr_words + ((m_awea1 != 4'h0) ? 2 : 1);
      if (m_aaddr0 < min_addr) min_addr <= m_aaddr0;
      if (m_awea1 != 4'h0) begin
        if (m_aaddr1 > max_addr) max_addr <= m_aaddr1;
      end else if (m_aaddr0 > max_addr) begin
        max_addr <= m_aaddr0;
      end
      bad_wr <= bad_wr
                + ((m_aaddr0 < 16'd1024 || m_aaddr0 > 16'd2199) ? 1 : 0)
                + ((m_awea1 != 4'h0 && (m_aaddr1 < 16'd1024 || m_aaddr1 > 16'd2199)) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_img(input logic [31:0] v);
    for (int i = 0; i < 256; i++) img_mem[i] = v;
  endtask

  task automatic fill_wt(input logic [31:0] k);
    for (int c = 0; c < 6; c++) begin
      for (int w = 0; w < 7; w++) wt_mem[c*8+w] = k;
      wt_mem[c*8+7] = 32'd0;
    end
  endtask

  task automatic clear_out();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input bit use_b);
    if (use_b) begin
      chk({tag, "_fin"}, 32'(ifb.finish), 32'd0);
      chk({tag, "_cen"}, 32'({ifb.weight_cen, ifb.act_cen}), 32'd3);
      chk({tag, "_addr"}, 32'(ifb.act_addr0 | ifb.act_addr1 | ifb.weight_addr0
                              | ifb.weight_addr1), 32'd0);
      chk({tag, "_wea_wdata"}, (ifb.act_wdata0 | ifb.act_wdata1)
                               | 32'({ifb.act_wea0, ifb.act_wea1}), 32'd0);
    end else begin
      chk({tag, "_fin"}, 32'(ifa.finish), 32'd0);
      chk({tag, "_cen"}, 32'({ifa.weight_cen, ifa.act_cen}), 32'd3);
      chk({tag, "_addr"}, 32'(ifa.act_addr0 | ifa.act_addr1 | ifa.weight_addr0
                              | ifa.weight_addr1), 32'd0);
      chk({tag, "_wea_wdata"}, (ifa.act_wdata0 | ifa.act_wdata1)
                               | 32'({ifa.act_wea0, ifa.act_wea1}), 32'd0);
    end
  endtask

  // Start one layer, optionally re-pulse start at cycle pulse_at, and time the finish pulse.
  task automatic run_layer(input bit use_b, input int pulse_at, input string tag);
    int cnt;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    cnt = 1;
    while (cnt < 12000) begin
      if (use_b ? ifb.finish : ifa.finish) break;
      if (use_b) start_b = (cnt == pulse_at); else start_a = (cnt == pulse_at);
      @(negedge clk);
      cnt++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_finish_cycle"}, 32'(cnt), 32'd9103);
    @(negedge clk);
    chk_idle({tag, "_after"}, use_b);
  endtask

  task automatic check_ch(input int ch, input logic [31:0] exp, input string tag);
    int          bad;
    logic [31:0] obs;
    bad = 0;
    obs = exp;
    for (int a = 1024 + ch*196; a < 1024 + (ch+1)*196; a++) begin
      if (out_mem[a] !== exp) begin
        if (bad == 0) obs = out_mem[a];
        bad++;
      end
    end
    chk($sformatf("%s_ch%0d", tag, ch), obs, exp);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_words"}, 32'(wr_words), 32'd1176);
    chk({tag, "_bad_wr"}, 32'(bad_wr), 32'd0);
    chk({tag, "_wea_pattern"}, 32'(wea_err), 32'd0);
    chk({tag, "_bad_rd"}, 32'(bad_rd), 32'd0);
  endtask

  // Expected ch2 word for the impulse at pixel (10,12) with tap(i,j) = 5i+j.
  function automatic logic [31:0] imp_word(input int r, input int w);
    logic [31:0] v;
    int          c;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      c = 4*w + b;
      if (r >= 6 && r <= 10 && c >= 8 && c <= 12) v[8*b +: 8] = 8'(5*(10-r) + (12-c));
    end
    return v;
  endfunction

  initial begin
    int bad_imp;
    logic [31:0] obs_imp, exp_imp;
    int acc0;
    tests    = 0;
    fails    = 0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    clr      = 1'b0;
    wr_words = 0; wr_cyc = 0; wea_err = 0; bad_wr = 0; bad_rd = 0; wwea_err = 0; acc_cnt = 0;
    for (int i = 0; i < 64; i++) wt_mem[i] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_a", 1'b0);
    chk_idle("reset_b", 1'b1);

    // All ones, SHIFT=0: 25 per output; a stray start mid-layer must not disturb it.
    fill_img(32'h0101_0101);
    fill_wt(32'h0101_0101);
    clear_out();
    run_layer(1'b0, 3000, "ones");
    for (int c = 0; c < 6; c++) check_ch(c, 32'h1919_1919, "ones");
    check_stats("ones");

    // Impulse through a ramp kernel on channel 2 only.
    fill_img(32'h0);
    img_mem[83] = 32'h0000_0001;
    fill_wt(32'h0);
    wt_mem[16] = 32'h0302_0100; wt_mem[17] = 32'h0706_0504; wt_mem[18] = 32'h0B0A_0908;
    wt_mem[19] = 32'h0F0E_0D0C; wt_mem[20] = 32'h1312_1110; wt_mem[21] = 32'h1716_1514;
    wt_mem[22] = 32'h1B1A_1918;
    clear_out();
    run_layer(1'b0, -1, "impulse");
    chk("imp_r6_w2", out_mem[1416 + 6*7 + 2], 32'h1516_1718);
    chk("imp_r6_w3", out_mem[1416 + 6*7 + 3], 32'h0000_0014);
    chk("imp_r8_w3", out_mem[1416 + 8*7 + 3], 32'h0000_000A);
    chk("imp_r10_w2", out_mem[1416 + 10*7 + 2], 32'h0102_0304);
    chk("imp_r10_w3", out_mem[1416 + 10*7 + 3], 32'h0000_0000);
    chk("imp_r5_w2", out_mem[1416 + 5*7 + 2], 32'h0000_0000);
    bad_imp = 0;
    obs_imp = '0;
    exp_imp = '0;
    for (int r = 0; r < 28; r++) begin
      for (int w = 0; w < 7; w++) begin
        if (out_mem[1416 + r*7 + w] !== imp_word(r, w) && bad_imp == 0) begin
          obs_imp = out_mem[1416 + r*7 + w];
          exp_imp = imp_word(r, w);
          bad_imp++;
        end
      end
    end
    chk("imp_ch2_sweep", obs_imp, exp_imp);
    for (int c = 0; c < 6; c++) if (c != 2) check_ch(c, 32'h0, "impulse");

    // Negative weights: every sum is -25, ReLU clamps to zero.
    fill_img(32'h0101_0101);
    fill_wt(32'hFFFF_FFFF);
    clear_out();
    run_layer(1'b1, -1, "relu");
    for (int c = 0; c < 6; c++) check_ch(c, 32'h0, "relu");

    // 403225 >> 8 = 1575 saturates to 127.
    fill_img(32'h7F7F_7F7F);
    fill_wt(32'h7F7F_7F7F);
    clear_out();
    run_layer(1'b1, -1, "sat");
    for (int c = 0; c < 6; c++) check_ch(c, 32'h7F7F_7F7F, "sat");

    // Bias only: 256*(ch+1) >> 8 = ch+1 in every byte.
    fill_wt(32'h0);
    for (int c = 0; c < 6; c++) wt_mem[c*8+7] = 32'(256 * (c + 1));
    clear_out();
    run_layer(1'b1, -1, "bias");
    for (int c = 0; c < 6; c++) check_ch(c, 32'h0101_0101 * 32'(c + 1), "bias");
    check_stats("bias");
    chk("bias_min_addr", 32'(min_addr), 32'd1024);
    chk("bias_max_addr", 32'(max_addr), 32'd2199);
    chk("weight_wea_zero", 32'(wwea_err), 32'd0);

    // Reset in the middle of ch1 row 0 COMP (cycle 1553), then rerun the all-ones layer.
    fill_img(32'h0101_0101);
    fill_wt(32'h0101_0101);
    clear_out();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (1552) @(negedge clk);
    chk("midcomp_no_access", 32'(ifa.act_cen), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("rst_mid", 1'b0);
    acc0 = acc_cnt;
    repeat (20) @(negedge clk);
    chk("rst_mid_quiet", 32'(acc_cnt - acc0), 32'd0);
    clear_out();
    run_layer(1'b0, -1, "rerun");
    for (int c = 0; c < 6; c++) check_ch(c, 32'h1919_1919, "rerun");
    check_stats("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
